mac_tx_arbiter: RTL and testbench

//  Frame-granular round-robin arbiter sharing the tri-mode MAC 8-bit TX AXI-Stream among
//  NUM_SRC frame sources (e.g. ADC sample UDP stream, ARP/ICMP reply engine). Locks the grant
//  for a whole frame, enforces a minimum idle gap between frames, and truncates oversize frames.

---
 rtl/mac_tx_arbiter_if.sv | 14 +
 rtl/mac_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_mac_tx_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_tx_arbiter_if.sv
// Byte-wide AXI-Stream bundle carrying NUM_LANES parallel lanes.
// Lane i uses tdata[8*i +: 8] and bit i of each control vector.
interface mac_tx_arbiter_if #(
   parameter int NUM_LANES = 1
);
   logic [8*NUM_LANES-1:0] tdata;
   logic [NUM_LANES-1:0]   tvalid;
   logic [NUM_LANES-1:0]   tlast;
   logic [NUM_LANES-1:0]   tuser;
   logic [NUM_LANES-1:0]   tready;

   modport master (output tdata, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter feeding the MAC 8-bit TX AXI-Stream.
// Locks the grant for a frame, inserts an idle gap after it, and truncates oversize frames.
module mac_tx_arbiter #(
   parameter int NUM_SRC         = 2,
   parameter int GAP_CYCLES      = 4,
   parameter int MAX_FRAME_BYTES = 1514
) (
   input  logic                       clk_125m,
   input  logic                       rst,
   mac_tx_arbiter_if.slave            s,
   mac_tx_arbiter_if.master           m,
   output logic [$clog2(NUM_SRC)-1:0] grant_idx,
   output logic                       busy,
   output logic                       oversize_err,
   output logic                       underrun_err
);
   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int CNT_W = ($clog2(MAX_FRAME_BYTES + 1) > 11) ? $clog2(MAX_FRAME_BYTES + 1) : 11;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_FRAME_BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PASS, DRAIN, GAP} state_t;

   localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   grant_nxt, arb_idx;
   logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
   logic               oversize_nxt, underrun_nxt;
   logic [NUM_SRC-1:0] grant_oh;
   logic [7:0]         sel_data;
   logic               sel_valid, sel_last, sel_user;

   assign grant_oh  = NUM_SRC'(1) << grant_idx;
   assign sel_data  = s.tdata[8*grant_idx +: 8];
   assign sel_valid = s.tvalid[grant_idx];
   assign sel_last  = s.tlast[grant_idx];
   assign sel_user  = s.tuser[grant_idx];
   assign busy      = (state != IDLE);

   // Scan from the farthest candidate to the nearest so the source right after the
   // last grant wins; the last granted source itself is visited first, i.e. lowest priority.
   always_comb begin
      arb_idx = grant_idx;
      for (int i = NUM_SRC; i >= 1; i--) begin
         if (s.tvalid[(int'(grant_idx) + i) % NUM_SRC]) begin
            arb_idx = IDX_W'((int'(grant_idx) + i) % NUM_SRC);
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant_idx;
      byte_cnt_nxt = byte_cnt;
      gap_cnt_nxt  = gap_cnt;
      oversize_nxt = 1'b0;
      underrun_nxt = 1'b0;
      s.tready     = '0;
      m.tdata      = '0;
      m.tvalid     = 1'b0;
      m.tlast      = 1'b0;
      m.tuser      = 1'b0;

      case (state)
         IDLE: begin
            if (|s.tvalid) begin
               grant_nxt    = arb_idx;
               byte_cnt_nxt = '0;
               state_nxt    = PASS;
            end
         end

         PASS: begin
            m.tdata  = sel_data;
            m.tvalid = sel_valid;
            m.tlast  = sel_last;
            m.tuser  = sel_user;
            s.tready = {NUM_SRC{m.tready}} & grant_oh;
            if (sel_valid && m.tready) begin
               byte_cnt_nxt = byte_cnt + CNT_W'(1);
               if (sel_last) begin
                  gap_cnt_nxt = '0;
                  state_nxt   = AFTER_FRAME;
               end else if (byte_cnt == LAST_BEAT) begin
                  // Close the frame towards the MAC as errored; the rest is drained.
                  m.tlast      = 1'b1;
                  m.tuser      = 1'b1;
                  oversize_nxt = 1'b1;
                  state_nxt    = DRAIN;
               end
            end else if (!sel_valid && byte_cnt != '0) begin
               underrun_nxt = 1'b1;
            end
         end

         DRAIN: begin
            s.tready = grant_oh;
            if (sel_valid && sel_last) begin
               gap_cnt_nxt = '0;
               state_nxt   = AFTER_FRAME;
            end
         end

         GAP: begin
            gap_cnt_nxt = gap_cnt + GAP_W'(1);
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_125m) begin
      if (rst) begin
         state        <= IDLE;
         grant_idx    <= IDX_W'(NUM_SRC - 1);
         byte_cnt     <= '0;
         gap_cnt      <= '0;
         oversize_err <= 1'b0;
         underrun_err <= 1'b0;
      end else begin
         state        <= state_nxt;
         grant_idx    <= grant_nxt;
         byte_cnt     <= byte_cnt_nxt;
         gap_cnt      <= gap_cnt_nxt;
         oversize_err <= oversize_nxt;
         underrun_err <= underrun_nxt;
      end
   end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: queue-driven sources, an output beat log,
// and per-scenario tasks comparing the log against hand-derived expectations.
module tb_mac_tx_arbiter;
   localparam int NUM_SRC         = 2;
   localparam int GAP_CYCLES      = 4;
   localparam int MAX_FRAME_BYTES = 1514;
   localparam int IDX_W           = $clog2(NUM_SRC);

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   logic             clk_125m = 1'b0;
   logic             rst      = 1'b1;
   logic [IDX_W-1:0] grant_idx;
   logic             busy, oversize_err, underrun_err;

   mac_tx_arbiter_if #(.NUM_LANES(NUM_SRC)) s_if ();
   mac_tx_arbiter_if #(.NUM_LANES(1))       m_if ();

   mac_tx_arbiter #(
      .NUM_SRC        (NUM_SRC),
      .GAP_CYCLES     (GAP_CYCLES),
      .MAX_FRAME_BYTES(MAX_FRAME_BYTES)
   ) dut (
      .clk_125m    (clk_125m),
      .rst         (rst),
      .s           (s_if),
      .m           (m_if),
      .grant_idx   (grant_idx),
      .busy        (busy),
      .oversize_err(oversize_err),
      .underrun_err(underrun_err)
   );

   always #4 clk_125m = ~clk_125m;

   int               vectors     = 0;
   int               miscompares = 0;
   beat_t            sq [NUM_SRC][$];
   beat_t            out_q[$];
   beat_t            exp_q[$];
   int               grant_q[$];
   int               gap_q[$];
   logic             hold [NUM_SRC];
   bit               rand_ready;
   bit               prev_last;
   int               cyc, first_beat_cyc, idle_run, ovr_cnt, und_cnt, stray_cnt;
   logic             obs_valid, obs_busy;
   logic [IDX_W-1:0] obs_grant;

   function automatic beat_t mk_beat(int src, int f, int k, int len, bit err);
      beat_t b;
      b.data = 8'(src * 97 + f * 13 + k);
      b.last = (k == len - 1);
      b.user = err && (k == len - 1);
      return b;
   endfunction

   function automatic int frame_len(int src, int f);
      return 1 + ((f * 7 + src * 5) % 17);
   endfunction

   task automatic load_frame(int src, int f, int len, bit err);
      for (int k = 0; k < len; k++) sq[src].push_back(mk_beat(src, f, k, len, err));
   endtask

   task automatic expect_frame(int src, int f, int len, bit err);
      for (int k = 0; k < len; k++) exp_q.push_back(mk_beat(src, f, k, len, err));
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sq[i].size() > 0 && !hold[i]) begin
            s_if.tvalid[i]       = 1'b1;
            s_if.tdata[8*i +: 8] = sq[i][0].data;
            s_if.tlast[i]        = sq[i][0].last;
            s_if.tuser[i]        = sq[i][0].user;
         end else begin
            s_if.tvalid[i]       = 1'b0;
            s_if.tdata[8*i +: 8] = 8'h00;
            s_if.tlast[i]        = 1'b0;
            s_if.tuser[i]        = 1'b0;
         end
      end
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic clear_log();
      out_q.delete();
      exp_q.delete();
      grant_q.delete();
      gap_q.delete();
      prev_last      = 1'b1;
      cyc            = 0;
      first_beat_cyc = -1;
      idle_run       = 0;
      ovr_cnt        = 0;
      und_cnt        = 0;
      stray_cnt      = 0;
   endtask

   // Observe mid-cycle, let the edge happen, then retire accepted source beats and re-drive.
   task automatic cycle();
      logic [NUM_SRC-1:0] hs;
      beat_t              b;
      @(negedge clk_125m);
      cyc++;
      hs        = s_if.tready & s_if.tvalid;
      obs_valid = m_if.tvalid;
      obs_busy  = busy;
      obs_grant = grant_idx;
      if (m_if.tvalid && m_if.tready) begin
         b.data = m_if.tdata;
         b.last = m_if.tlast;
         b.user = m_if.tuser;
         if (prev_last) begin
            grant_q.push_back(int'(grant_idx));
            if (out_q.size() > 0) gap_q.push_back(idle_run);
         end
         if (out_q.size() == 0) first_beat_cyc = cyc;
         out_q.push_back(b);
         prev_last = b.last;
         idle_run  = 0;
      end else begin
         idle_run++;
      end
      if (oversize_err) ovr_cnt++;
      if (underrun_err) und_cnt++;
      if ($countones(s_if.tready) > 1) stray_cnt++;
      @(posedge clk_125m);
      #1;
      for (int i = 0; i < NUM_SRC; i++) if (hs[i]) void'(sq[i].pop_front());
      drive_inputs();
   endtask

   task automatic run_until(int beats, int budget);
      for (int t = 0; t < budget && out_q.size() < beats; t++) cycle();
   endtask

   task automatic apply_reset();
      rst        = 1'b1;
      rand_ready = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sq[i].delete();
         hold[i] = 1'b0;
      end
      drive_inputs();
      repeat (2) @(posedge clk_125m);
      #1 rst = 1'b0;
      clear_log();
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata} !== 11'b0) begin
         miscompares++;
         $display("FAIL reset_m_bus: got %h want 000", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata});
      end
      vectors++;
      if ({busy, s_if.tready, oversize_err, underrun_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got busy/tready/errs %b want 00000", {busy, s_if.tready, oversize_err, underrun_err});
      end
      vectors++;
      if (grant_idx !== IDX_W'(NUM_SRC - 1)) begin
         miscompares++;
         $display("FAIL reset_grant: got %0d want %0d", grant_idx, NUM_SRC - 1);
      end
   endtask

   task automatic test_single_frame();
      int lasts;
      apply_reset();
      load_frame(0, 0, 60, 1'b0);
      expect_frame(0, 0, 60, 1'b0);
      drive_inputs();
      run_until(60, 200);
      vectors++;
      if (first_beat_cyc !== 2) begin
         miscompares++;
         $display("FAIL t1_latency: first beat at cycle %0d want 2", first_beat_cyc);
      end
      vectors++;
      if (out_q.size() != 60) begin
         miscompares++;
         $display("FAIL t1_len: got %0d beats want 60", out_q.size());
      end else begin
         lasts = 0;
         for (int k = 0; k < 60; k++) begin
            if (out_q[k].last) lasts++;
            vectors++;
            if (out_q[k] !== exp_q[k]) begin
               miscompares++;
               $display("FAIL t1_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
               break;
            end
         end
         vectors++;
         if (lasts != 1) begin
            miscompares++;
            $display("FAIL t1_tlast_count: got %0d want 1", lasts);
         end
      end
      for (int k = 0; k < 5; k++) begin
         cycle();
         vectors++;
         if ({obs_valid, obs_busy, obs_grant} !== {1'b0, k < 4, IDX_W'(0)}) begin
            miscompares++;
            $display("FAIL t1_gap%0d: got valid/busy/grant %b want %b", k, {obs_valid, obs_busy, obs_grant}, {1'b0, k < 4, IDX_W'(0)});
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int f = 0; f < 2; f++) begin
         load_frame(0, f, 64, 1'b0);
         load_frame(1, f, 64, 1'b0);
         expect_frame(0, f, 64, 1'b0);
         expect_frame(1, f, 64, 1'b0);
      end
      drive_inputs();
      run_until(256, 1000);
      vectors++;
      if (out_q.size() != 256) begin
         miscompares++;
         $display("FAIL t2_len: got %0d beats want 256", out_q.size());
      end else begin
         for (int k = 0; k < 256; k++) begin
            vectors++;
            if (out_q[k] !== exp_q[k]) begin
               miscompares++;
               $display("FAIL t2_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
               break;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= grant_q.size() || grant_q[i] != i % 2) begin
            miscompares++;
            $display("FAIL t2_order%0d: got %0d want %0d", i, (i < grant_q.size()) ? grant_q[i] : -1, i % 2);
         end
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (i >= gap_q.size() || gap_q[i] != GAP_CYCLES + 1) begin
            miscompares++;
            $display("FAIL t2_gap%0d: got %0d idle cycles want %0d", i, (i < gap_q.size()) ? gap_q[i] : -1, GAP_CYCLES + 1);
         end
      end
   endtask

   task automatic test_oversize();
      beat_t b;
      apply_reset();
      load_frame(1, 0, 1600, 1'b0);
      drive_inputs();
      repeat (3) cycle();
      load_frame(0, 0, 10, 1'b0);
      drive_inputs();
      for (int k = 0; k < MAX_FRAME_BYTES; k++) begin
         b = mk_beat(1, 0, k, 1600, 1'b0);
         if (k == MAX_FRAME_BYTES - 1) begin
            b.last = 1'b1;
            b.user = 1'b1;
         end
         exp_q.push_back(b);
      end
      expect_frame(0, 0, 10, 1'b0);
      run_until(MAX_FRAME_BYTES + 10, 3000);
      vectors++;
      if (out_q.size() != MAX_FRAME_BYTES + 10) begin
         miscompares++;
         $display("FAIL t3_len: got %0d beats want %0d", out_q.size(), MAX_FRAME_BYTES + 10);
      end else begin
         for (int k = 0; k < MAX_FRAME_BYTES + 10; k++) begin
            vectors++;
            if (out_q[k] !== exp_q[k]) begin
               miscompares++;
               $display("FAIL t3_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
               break;
            end
         end
      end
      vectors++;
      if (ovr_cnt != 1) begin
         miscompares++;
         $display("FAIL t3_oversize_pulses: got %0d want 1", ovr_cnt);
      end
      vectors++;
      if (sq[1].size() != 0) begin
         miscompares++;
         $display("FAIL t3_drain: %0d src1 beats left want 0", sq[1].size());
      end
      vectors++;
      if (gap_q.size() != 1 || gap_q[0] != 1600 - MAX_FRAME_BYTES + GAP_CYCLES + 1) begin
         miscompares++;
         $display("FAIL t3_gap: got %0d idle cycles want %0d", (gap_q.size() > 0) ? gap_q[0] : -1, 1600 - MAX_FRAME_BYTES + GAP_CYCLES + 1);
      end
      vectors++;
      if (grant_q.size() != 2 || grant_q[0] != 1 || grant_q[1] != 0) begin
         miscompares++;
         $display("FAIL t3_order: got %p want '{1, 0}", grant_q);
      end
   endtask

   task automatic test_random_ready();
      int total;
      apply_reset();
      rand_ready = 1'b1;
      total      = 0;
      for (int f = 0; f < 10; f++) begin
         for (int src = 0; src < NUM_SRC; src++) begin
            load_frame(src, f, frame_len(src, f), f == 3);
            expect_frame(src, f, frame_len(src, f), f == 3);
            total += frame_len(src, f);
         end
      end
      drive_inputs();
      run_until(total, 5000);
      vectors++;
      if (out_q.size() != total) begin
         miscompares++;
         $display("FAIL t4_len: got %0d beats want %0d", out_q.size(), total);
      end else begin
         for (int k = 0; k < total; k++) begin
            vectors++;
            if (out_q[k] !== exp_q[k]) begin
               miscompares++;
               $display("FAIL t4_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
               break;
            end
         end
      end
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if (i >= grant_q.size() || grant_q[i] != i % 2) begin
            miscompares++;
            $display("FAIL t4_order%0d: got %0d want %0d", i, (i < grant_q.size()) ? grant_q[i] : -1, i % 2);
            break;
         end
      end
      vectors++;
      if (stray_cnt != 0 || und_cnt != 0) begin
         miscompares++;
         $display("FAIL t4_ready_onehot: stray %0d underrun %0d want 0 0", stray_cnt, und_cnt);
      end
      rand_ready = 1'b0;
   endtask

   task automatic test_underrun();
      apply_reset();
      load_frame(0, 2, 20, 1'b0);
      expect_frame(0, 2, 20, 1'b0);
      drive_inputs();
      run_until(8, 50);
      hold[0] = 1'b1;
      drive_inputs();
      repeat (3) cycle();
      hold[0] = 1'b0;
      drive_inputs();
      run_until(20, 100);
      repeat (2) cycle();
      vectors++;
      if (und_cnt != 3) begin
         miscompares++;
         $display("FAIL t5_underrun_cycles: got %0d want 3", und_cnt);
      end
      vectors++;
      if (out_q.size() != 20) begin
         miscompares++;
         $display("FAIL t5_len: got %0d beats want 20", out_q.size());
      end else begin
         for (int k = 0; k < 20; k++) begin
            vectors++;
            if (out_q[k] !== exp_q[k]) begin
               miscompares++;
               $display("FAIL t5_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
               break;
            end
         end
      end
      vectors++;
      if (grant_q.size() != 1 || grant_q[0] != 0) begin
         miscompares++;
         $display("FAIL t5_grant: got %p want '{0}", grant_q);
      end
   endtask

   task automatic test_reset_mid_frame();
      int lasts;
      apply_reset();
      load_frame(0, 4, 50, 1'b0);
      drive_inputs();
      run_until(29, 100);
      rst = 1'b1;
      cycle();
      lasts = 0;
      foreach (out_q[k]) if (out_q[k].last) lasts++;
      vectors++;
      if (out_q.size() != 30 || lasts != 0) begin
         miscompares++;
         $display("FAIL t6_beats_before_rst: got %0d beats %0d tlast want 30 0", out_q.size(), lasts);
      end
      vectors++;
      if ({m_if.tvalid, s_if.tready, busy} !== 4'b0 || grant_idx !== IDX_W'(NUM_SRC - 1)) begin
         miscompares++;
         $display("FAIL t6_after_rst: got valid/tready/busy %b grant %0d want 0000 %0d", {m_if.tvalid, s_if.tready, busy}, grant_idx, NUM_SRC - 1);
      end
      rst = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) sq[i].delete();
      clear_log();
      load_frame(0, 5, 5, 1'b0);
      expect_frame(0, 5, 5, 1'b0);
      drive_inputs();
      run_until(5, 50);
      vectors++;
      if (out_q.size() != 5 || first_beat_cyc != 2 || grant_q.size() != 1 || grant_q[0] != 0) begin
         miscompares++;
         $display("FAIL t6_rearb: got %0d beats first at %0d grants %p want 5 2 '{0}", out_q.size(), first_beat_cyc, grant_q);
      end else begin
         for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_q[k] !== exp_q[k]) begin
               miscompares++;
               $display("FAIL t6_beat%0d: got %h want %h", k, out_q[k], exp_q[k]);
               break;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_oversize();
      test_random_ready();
      test_underrun();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
